shift_frame_engine: RTL and testbench

SHIFT_FRAME_ENGINE -- requirements
Module: shift_frame_engine

---
 rtl/shift_frame_engine.sv | 77 +++++++
 tb/tb_shift_frame_engine.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_frame_engine.sv
// Framed shift register: loads in IDLE, shifts WIDTH bits on strobes,
// pulses done at frame end, and supports abort and LSB/MSB-first order.
module shift_frame_engine #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             peripheralClkEdge,
  input  logic             parallelLoad,
  input  logic [WIDTH-1:0] parallelDataIn,
  input  logic             serialDataIn,
  input  logic             msbFirst,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] parallelDataOut,
  output logic             serialDataOut,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bitCount
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shiftReg;
  logic             modeBit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shiftReg <= '0;
      modeBit  <= 1'b0;
      bitCount <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          modeBit <= msbFirst;
          if (parallelLoad)
            shiftReg <= parallelDataIn;
          if (start) begin
            state    <= SHIFT;
            bitCount <= '0;
          end
        end
        SHIFT: begin
          // abort wins over a same-cycle strobe
          if (abort) begin
            state <= IDLE;
          end else if (peripheralClkEdge) begin
            if (modeBit)
              shiftReg <= {shiftReg[WIDTH-2:0], serialDataIn};
            else
              shiftReg <= {serialDataIn, shiftReg[WIDTH-1:1]};
            bitCount <= bitCount + CNT_W'(1);
            if (bitCount == LAST)
              state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign parallelDataOut = shiftReg;
  assign serialDataOut   = modeBit ? shiftReg[WIDTH-1] : shiftReg[0];
  assign busy            = (state == SHIFT);
  assign done            = (state == DONE);

endmodule

// File: tb/tb_shift_frame_engine.sv
// Bench for shift_frame_engine: directed frames from the requirement
// vectors plus random traffic checked against a behavioural model.
module tb_shift_frame_engine;

  localparam int W = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          strobe;
  logic          load;
  logic [W-1:0]  pdi;
  logic          sin;
  logic          msb;
  logic          start;
  logic          abort;
  logic [W-1:0]  pdo;
  logic          sdo;
  logic          busy;
  logic          done;
  logic [CW-1:0] cnt;

  int nAsserts = 0;
  int nFails = 0;

  // model: phase 0 idle, 1 framing, 2 frame-complete cycle
  int       mPhase;
  int       mReg;
  int       mMode;
  int       mCnt;
  int       prevDone;

  shift_frame_engine #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .peripheralClkEdge(strobe),
    .parallelLoad(load),
    .parallelDataIn(pdi),
    .serialDataIn(sin),
    .msbFirst(msb),
    .start(start),
    .abort(abort),
    .parallelDataOut(pdo),
    .serialDataOut(sdo),
    .busy(busy),
    .done(done),
    .bitCount(cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp)
    else begin
      nFails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void modelReset();
    mPhase = 0;
    mReg   = 0;
    mMode  = 0;
    mCnt   = 0;
  endfunction

  // next-state of the frame model, evaluated from inputs before the edge
  function automatic void modelEdge();
    if (!rst_n) begin
      modelReset();
    end else if (mPhase == 0) begin
      mMode = int'(msb);
      if (load) mReg = int'(pdi);
      if (start) begin
        mPhase = 1;
        mCnt   = 0;
      end
    end else if (mPhase == 1) begin
      if (abort) begin
        mPhase = 0;
      end else if (strobe) begin
        if (mMode != 0)
          mReg = ((mReg * 2) + int'(sin)) % (1 << W);
        else
          mReg = (mReg / 2) + int'(sin) * (1 << (W - 1));
        mCnt++;
        if (mCnt == W) mPhase = 2;
      end
    end else begin
      mPhase = 0;
    end
  endfunction

  function automatic int modelSdo();
    return (mMode != 0) ? (mReg >> (W - 1)) & 1 : mReg & 1;
  endfunction

  task automatic checkAll(input string tag);
    chk({tag, ".pdo"}, 32'(pdo), mReg);
    chk({tag, ".sdo"}, 32'(sdo), modelSdo());
    chk({tag, ".busy"}, 32'(busy), 32'(mPhase == 1));
    chk({tag, ".done"}, 32'(done), 32'(mPhase == 2));
    chk({tag, ".cnt"}, 32'(cnt), mCnt);
    chk({tag, ".cntMax"}, 32'(cnt <= W), 1);
    chk({tag, ".doneRun"}, 32'(done && prevDone != 0), 0);
    prevDone = int'(done);
  endtask

  task automatic tick();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    strobe = 0; load = 0; start = 0; abort = 0;
  endtask

  logic [7:0] seqA;
  logic [7:0] seqB;

  initial begin
    rst_n = 1'b0;
    pdi = '0; sin = 0; msb = 0;
    idleInputs();
    prevDone = 0;
    modelReset();
    #12;
    checkAll("reset");
    tick();
    checkAll("resetHeld");
    rst_n = 1'b1;
    tick();
    checkAll("postReset");

    // LSB-first frame of 0xA5 shifting in ones
    seqA = 8'b1010_0101;
    pdi = 8'hA5; load = 1; msb = 0;
    tick(); checkAll("lsbLoad");
    load = 0; start = 1;
    tick(); checkAll("lsbStart");
    start = 0; sin = 1;
    for (int i = 0; i < 8; i++) begin
      chk("lsbSdo", 32'(sdo), 32'(seqA[i]));
      strobe = 1;
      tick(); checkAll("lsbShift");
    end
    strobe = 0;
    chk("lsbFinal", 32'(pdo), 32'hFF);
    chk("lsbCnt", 32'(cnt), 8);
    chk("lsbDone", 32'(done), 1);
    tick(); checkAll("lsbAfter");
    chk("lsbDoneOff", 32'(done), 0);

    // MSB-first frame with load and start together
    seqB = 8'b0011_1100;
    pdi = 8'h3C; load = 1; start = 1; msb = 1; sin = 0;
    tick(); checkAll("msbStart");
    load = 0; start = 0;
    for (int i = 0; i < 8; i++) begin
      chk("msbSdo", 32'(sdo), 32'(seqB[7 - i]));
      chk("msbBusy", 32'(busy), 1);
      strobe = 1;
      tick(); checkAll("msbShift");
    end
    strobe = 0;
    chk("msbFinal", 32'(pdo), 0);
    tick(); checkAll("msbAfter");

    // long pause mid-frame with msbFirst and load disturbances
    pdi = 8'($urandom); load = 1; start = 1; msb = 1'($urandom);
    tick(); checkAll("pauseStart");
    load = 0; start = 0;
    for (int i = 0; i < 4; i++) begin
      strobe = 1; sin = 1'($urandom);
      tick(); checkAll("pauseShiftA");
    end
    strobe = 0;
    for (int i = 0; i < 20; i++) begin
      msb = ~msb;
      load = (i == 10); pdi = 8'hFF;
      tick(); checkAll("pauseHold");
    end
    load = 0;
    chk("pauseCnt", 32'(cnt), 4);
    for (int i = 0; i < 4; i++) begin
      strobe = 1; sin = 1'($urandom);
      tick(); checkAll("pauseShiftB");
    end
    strobe = 0;
    chk("pauseDone", 32'(done), 1);
    tick(); checkAll("pauseAfter");

    // abort after three strobes, abort beating a same-cycle strobe
    pdi = 8'hA5; load = 1; start = 1; msb = 0; sin = 0;
    tick(); checkAll("abortStart");
    load = 0; start = 0;
    for (int i = 0; i < 3; i++) begin
      strobe = 1;
      tick(); checkAll("abortShift");
    end
    abort = 1;
    tick(); checkAll("abortEdge");
    abort = 0; strobe = 0;
    chk("abortPdo", 32'(pdo), 32'h14);
    chk("abortCnt", 32'(cnt), 3);
    chk("abortBusy", 32'(busy), 0);
    for (int i = 0; i < 3; i++) begin
      tick(); checkAll("abortIdle");
    end
    start = 1;
    tick(); checkAll("restart");
    start = 0;
    for (int i = 0; i < 8; i++) begin
      strobe = 1; sin = 1'($urandom);
      tick(); checkAll("restartShift");
    end
    strobe = 0;
    chk("restartDone", 32'(done), 1);
    tick(); checkAll("restartAfter");

    // random traffic, heavy strobes
    for (int i = 0; i < 400; i++) begin
      strobe = ($urandom_range(0, 3) != 0);
      load   = ($urandom_range(0, 3) == 0);
      start  = ($urandom_range(0, 3) == 0);
      abort  = ($urandom_range(0, 15) == 0);
      msb    = 1'($urandom);
      sin    = 1'($urandom);
      pdi    = 8'($urandom);
      tick(); checkAll("random");
    end
    idleInputs();
    tick(); tick(); checkAll("randomEnd");

    // asynchronous reset mid-frame
    pdi = 8'($urandom); load = 1; start = 1; msb = 1'($urandom);
    tick(); checkAll("rstStart");
    load = 0; start = 0;
    for (int i = 0; i < 5; i++) begin
      strobe = 1; sin = 1'($urandom);
      tick(); checkAll("rstShift");
    end
    strobe = 0;
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkAll("rstAsync");
    chk("rstPdo", 32'(pdo), 0);
    chk("rstBusy", 32'(busy), 0);
    chk("rstCnt", 32'(cnt), 0);
    strobe = 1; start = 1;
    tick(); checkAll("rstHold");
    idleInputs();
    rst_n = 1'b1;
    tick(); checkAll("rstRelease");

    $display("End of test - %0d assertions evaluated, %0d failures",
             nAsserts, nFails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
